// File: rtl/sparse_mask_encoder_pkg.sv
// Shared definitions for the sparse mask encoder and the mask matcher that
// consumes its bitmask/payload stream.
package sparse_mask_encoder_pkg;

    localparam int VAL_WIDTH_DEFAULT  = 8;
    localparam int BLOCK_SIZE_DEFAULT = 16;
    localparam int OUT_LANES_DEFAULT  = 2;
    localparam int NUM_DENSE_WIDTH    = 2;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        EMIT_MASK = 2'd1,
        EMIT_DATA = 2'd2
    } encState_e;

endpackage

// File: rtl/sparse_mask_encoder.sv
// Compresses a block of dense values into a bitmask header followed by the
// nonzero values packed OUT_LANES per beat, in original position order.
module sparse_mask_encoder
    import sparse_mask_encoder_pkg::*;
#(
    parameter int VAL_WIDTH  = VAL_WIDTH_DEFAULT,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEFAULT,
    parameter int OUT_LANES  = OUT_LANES_DEFAULT
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [VAL_WIDTH-1:0]       in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_SIZE-1:0]      out_data,
    output logic                       out_is_mask,
    output logic [NUM_DENSE_WIDTH-1:0] out_num_dense,
    output logic                       out_last,
    output logic [1:0]                 dbgState
);

    // Both ports use valid/ready: a beat transfers on a rising edge where
    // valid && ready; the producer holds its beat stable until then.

    localparam int POS_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
    localparam int PAY_W = OUT_LANES * VAL_WIDTH;

    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W:0]   LANES_EXT = (CNT_W + 1)'(OUT_LANES);
    localparam logic [CNT_W-1:0] LANES_CNT = CNT_W'(OUT_LANES);

    encState_e state;
    encState_e stateNext;

    logic                  alive;
    logic [POS_W-1:0]      pos;
    logic [CNT_W-1:0]      nnz;
    logic [CNT_W-1:0]      rd;
    logic [BLOCK_SIZE-1:0] mask;
    logic [VAL_WIDTH-1:0]  packedVals [BLOCK_SIZE];

    logic             inFire;
    logic             outFire;
    logic             inNonzero;
    logic             blockDone;
    logic [CNT_W:0]   remaining;
    logic             dataLast;
    logic [PAY_W-1:0] payload;
    logic [CNT_W-1:0] laneIdx;

    assign inNonzero = (in_data != '0);
    assign inFire    = in_valid && in_ready;
    assign outFire   = out_valid && out_ready;
    assign blockDone = inFire && (in_last || (pos == LAST_POS));
    // Only meaningful in EMIT_DATA, where rd < nnz always holds.
    assign remaining = {1'b0, nnz} - {1'b0, rd};
    assign dataLast  = (remaining <= LANES_EXT);
    assign dbgState  = state;

    always_comb begin
        stateNext = state;
        case (state)
            COLLECT: begin
                if (blockDone) stateNext = EMIT_MASK;
            end
            EMIT_MASK: begin
                if (outFire) stateNext = (nnz == '0) ? COLLECT : EMIT_DATA;
            end
            EMIT_DATA: begin
                if (outFire && dataLast) stateNext = COLLECT;
            end
            default: stateNext = COLLECT;
        endcase
    end

    always_comb begin
        payload = '0;
        laneIdx = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            laneIdx = rd + CNT_W'(i);
            if (laneIdx < nnz) begin
                payload[i*VAL_WIDTH +: VAL_WIDTH] = packedVals[laneIdx[POS_W-1:0]];
            end
        end
    end

    // Outputs decode from registers only, so they hold while stalled.
    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_is_mask   = 1'b0;
        out_last      = 1'b0;
        out_data      = '0;
        out_num_dense = '0;
        case (state)
            COLLECT: begin
                in_ready = alive;
            end
            EMIT_MASK: begin
                out_valid   = 1'b1;
                out_is_mask = 1'b1;
                out_data    = mask;
                out_last    = (nnz == '0);
            end
            EMIT_DATA: begin
                out_valid     = 1'b1;
                out_data      = BLOCK_SIZE'(payload);
                out_last      = dataLast;
                out_num_dense = (remaining >= LANES_EXT) ? NUM_DENSE_WIDTH'(OUT_LANES)
                                                         : NUM_DENSE_WIDTH'(remaining);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= COLLECT;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            alive <= 1'b0;
            pos   <= '0;
            nnz   <= '0;
            rd    <= '0;
            mask  <= '0;
        end else begin
            alive <= 1'b1;
            case (state)
                COLLECT: begin
                    if (inFire) begin
                        mask[pos] <= inNonzero;
                        pos       <= pos + 1'b1;
                        if (inNonzero) nnz <= nnz + 1'b1;
                    end
                end
                EMIT_MASK: begin
                    if (outFire) begin
                        rd <= '0;
                        if (nnz == '0) begin
                            pos  <= '0;
                            mask <= '0;
                        end
                    end
                end
                EMIT_DATA: begin
                    if (outFire) begin
                        if (dataLast) begin
                            pos  <= '0;
                            nnz  <= '0;
                            rd   <= '0;
                            mask <= '0;
                        end else begin
                            rd <= rd + LANES_CNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: nnz bounds every read.
    always_ff @(posedge clock) begin
        if (state == COLLECT && inFire && inNonzero) begin
            packedVals[nnz[POS_W-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_sparse_mask_encoder.sv
// Bench for sparse_mask_encoder: directed blocks plus random blocks checked
// beat-by-beat and through a mask-matcher style loopback decode.
module tb_sparse_mask_encoder;
    import sparse_mask_encoder_pkg::*;

    localparam int VW = 8;
    localparam int BS = 16;
    localparam int OL = 2;
    localparam int BW = BS + 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BS-1:0] out_data;
    logic          out_is_mask;
    logic [1:0]    out_num_dense;
    logic          out_last;
    logic [1:0]    dbgState;

    sparse_mask_encoder #(.VAL_WIDTH(VW), .BLOCK_SIZE(BS), .OUT_LANES(OL)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_mask(out_is_mask), .out_num_dense(out_num_dense), .out_last(out_last),
        .dbgState(dbgState)
    );

    always #5 clock = ~clock;

    int errCnt = 0;
    int chkCnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [BW-1:0] exp_q[$];
    logic [31:0]   gold_q[$];
    logic [VW-1:0] blk[BS];
    logic [BS-1:0] wMask = 16'hF00F;
    int readyMode = 0;
    int tog = 0;
    int cycle = 0;
    int hdrCycle = 0;
    int lastCycle = 0;

    // Reference: mask of nonzero positions, nonzeros chunked OL per beat,
    // plus the weighted sum a matcher against wMask would see.
    task automatic push_expected(input int len);
        logic [BS-1:0] m;
        logic [VW-1:0] nz[$];
        logic [31:0]   gold;
        logic [BS-1:0] d;
        int n;
        m = '0;
        gold = 0;
        for (int i = 0; i < len; i++) begin
            if (blk[i] != 0) begin
                m[i] = 1'b1;
                nz.push_back(blk[i]);
                if (wMask[i]) gold += 32'((i + 1) * int'(blk[i]));
            end
        end
        exp_q.push_back({nz.size() == 0, 1'b1, 2'd0, m});
        for (int k = 0; k < nz.size(); k += OL) begin
            d = '0;
            n = nz.size() - k;
            if (n > OL) n = OL;
            for (int j = 0; j < n; j++) d[j*VW +: VW] = nz[k + j];
            exp_q.push_back({k + OL >= nz.size(), 1'b0, n[1:0], d});
        end
        gold_q.push_back(gold);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (readyMode)
                1: out_ready = ($urandom_range(0, 9) < 7);
                2: begin
                    out_ready = (tog == 0 || tog == 3);
                    tog = (tog + 1) % 4;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    logic          heldValid = 1'b0;
    logic [BW-1:0] heldBeat;
    logic [BS-1:0] recMask;
    logic [VW-1:0] recVals[$];

    always @(negedge clock) begin
        logic [BW-1:0] cur;
        logic [31:0]   sum;
        logic [VW-1:0] v;
        int k;
        cycle++;
        if (!resetn) begin
            heldValid = 1'b0;
            recVals.delete();
        end else begin
            cur = {out_last, out_is_mask, out_num_dense, out_data};
            if (heldValid) begin
                check_eq("stall_valid", 64'(out_valid), 1);
                if (out_valid) check_eq("stall_stable", 64'(cur), 64'(heldBeat));
            end
            if (out_valid) check_eq("in_ready_busy", 64'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_beat", 64'(exp_q.size()), 1);
                else check_eq("beat", 64'(cur), 64'(exp_q.pop_front()));
                if (out_is_mask) begin
                    recMask = out_data;
                    recVals.delete();
                    hdrCycle = cycle;
                end else begin
                    for (int j = 0; j < int'(out_num_dense); j++) recVals.push_back(out_data[j*VW +: VW]);
                end
                if (out_last) begin
                    lastCycle = cycle;
                    sum = 0;
                    k = 0;
                    for (int p = 0; p < BS; p++) begin
                        if (recMask[p]) begin
                            v = (k < recVals.size()) ? recVals[k] : '0;
                            k++;
                            if (wMask[p]) sum += 32'((p + 1) * int'(v));
                        end
                    end
                    if (gold_q.size() == 0) check_eq("unexpected_block", 64'(gold_q.size()), 1);
                    else check_eq("loopback", 64'(sum), 64'(gold_q.pop_front()));
                end
            end
            heldValid = out_valid && !out_ready;
            heldBeat  = cur;
        end
    end

    task automatic drive_beat(input logic [VW-1:0] v, input logic last);
        int t;
        bit ok;
        t = 0;
        ok = 0;
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        while (t < 200) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                break;
            end
            t++;
        end
        if (!ok) check_eq("in_ready_timeout", 64'(in_ready), 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = VW'($urandom);
    endtask

    task automatic send_block(input int len, input bit forceLast, input bit bubbles);
        push_expected(len);
        for (int i = 0; i < len; i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
            drive_beat(blk[i], (i == len - 1) && (len < BS || forceLast));
        end
        check_eq("hdr_timing", {62'd0, out_valid, out_is_mask}, 64'h3);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
            @(posedge clock);
            #1;
            t++;
        end
        check_eq("drain", 64'(exp_q.size()), 0);
        check_eq("ready_after_block", 64'(in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_out_valid", 64'(out_valid), 0);
        check_eq("rst_in_ready", 64'(in_ready), 0);
        check_eq("rst_is_mask", 64'(out_is_mask), 0);
        check_eq("rst_last", 64'(out_last), 0);
        check_eq("rst_data", 64'(out_data), 0);
        check_eq("rst_num_dense", 64'(out_num_dense), 0);
        check_eq("rst_state", 64'(dbgState), 64'(COLLECT));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check_eq("ready_after_reset", 64'(in_ready), 1);

        // Fully dense block, continuous out_ready
        readyMode = 0;
        for (int i = 0; i < BS; i++) blk[i] = VW'(i + 1);
        send_block(BS, 0, 0);
        check_eq("hdr_dense", 64'(out_data), 64'hFFFF);
        wait_drain();
        check_eq("throughput", 64'(lastCycle - hdrCycle), 8);

        // All-zero block: single header beat
        for (int i = 0; i < BS; i++) blk[i] = '0;
        send_block(BS, 0, 0);
        check_eq("hdr_zero", 64'(out_data), 64'h0000);
        check_eq("hdr_zero_last", 64'(out_last), 1);
        @(posedge clock);
        #1;
        check_eq("zero_ready_next", 64'(in_ready), 1);
        wait_drain();

        // Early termination 5,0,0,7,0,9
        blk[0] = 8'd5; blk[1] = 8'd0; blk[2] = 8'd0;
        blk[3] = 8'd7; blk[4] = 8'd0; blk[5] = 8'd9;
        send_block(6, 0, 0);
        check_eq("hdr_early", 64'(out_data), 64'h0029);
        wait_drain();

        // Stalling downstream 1,0,0,1
        tog = 0;
        readyMode = 2;
        for (int i = 0; i < BS; i++) blk[i] = VW'(i + 1);
        send_block(BS, 0, 0);
        wait_drain();
        readyMode = 0;

        // One-position blocks
        blk[0] = 8'h5A;
        send_block(1, 0, 0);
        check_eq("hdr_single", 64'(out_data), 64'h0001);
        wait_drain();
        blk[0] = 8'h00;
        send_block(1, 0, 0);
        wait_drain();

        // in_last on the final position
        for (int i = 0; i < BS; i++) blk[i] = ($urandom_range(0, 1) == 0) ? '0 : VW'($urandom_range(1, 255));
        send_block(BS, 1, 0);
        wait_drain();

        // Reset in the middle of a block
        for (int i = 0; i < 7; i++) drive_beat(VW'($urandom_range(1, 255)), 1'b0);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check_eq("midrst_valid", 64'(out_valid), 0);
        check_eq("midrst_ready", 64'(in_ready), 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check_eq("midrst_ready_after", 64'(in_ready), 1);
        for (int i = 0; i < BS; i++) blk[i] = 8'h03;
        send_block(BS, 0, 0);
        check_eq("hdr_after_rst", 64'(out_data), 64'hFFFF);
        wait_drain();

        // Random blocks, random backpressure and input bubbles
        readyMode = 1;
        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(1, BS);
            for (int i = 0; i < BS; i++) blk[i] = ($urandom_range(0, 1) == 0) ? '0 : VW'($urandom_range(1, 255));
            send_block(len, $urandom_range(0, 1) == 1, 1);
        end
        wait_drain();
        check_eq("gold_drain", 64'(gold_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/sparse_mask_encoder.md
SPARSE_MASK_ENCODER -- requirements
Module: sparse_mask_encoder

Interface
REQ-001 SHALL have parameter VAL_WIDTH, default 8: bit width of one activation/weight value.
REQ-002 SHALL have parameter BLOCK_SIZE, default 16: values per compression block, equal to the bitmask width.
REQ-003 SHALL have parameter OUT_LANES, default 2: packed values per payload beat.
REQ-004 SHALL have port clock  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1: synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1: in_data/in_last valid.
REQ-007 SHALL have port in_ready  output  1: encoder accepts an input beat.
REQ-008 SHALL have port in_data  input  VAL_WIDTH: one dense value, block position order 0..BLOCK_SIZE-1.
REQ-009 SHALL have port in_last  input  1: early block termination; remaining positions are zero.
REQ-010 SHALL have port out_valid  output  1: output beat valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the output beat.
REQ-012 SHALL have port out_data  output  BLOCK_SIZE: bitmask (header) or OUT_LANES packed values, lane 0 in LSBs.
REQ-013 SHALL have port out_is_mask  output  1: current beat is the bitmask header.
REQ-014 SHALL have port out_num_dense  output  2: valid payload lanes in the beat (0 on header).
REQ-015 SHALL have port out_last  output  1: final beat of the block.

Function
REQ-016 SHALL implement states COLLECT, EMIT_MASK, EMIT_DATA.
REQ-017 In COLLECT, in_ready SHALL be 1 and out_valid 0.
REQ-018 Each accepted beat SHALL set mask bit [pos] to (in_data != 0) and increment pos.
REQ-019 Each accepted nonzero beat SHALL be written to packed[nnz], then nnz SHALL increment, preserving position order.
REQ-020 Acceptance at pos == BLOCK_SIZE-1, or with in_last=1, SHALL move to EMIT_MASK next cycle; unfilled mask bits SHALL be 0.
REQ-021 Timing: final input accepted in cycle t SHALL give out_valid=1 with the header in cycle t+1.
REQ-022 In EMIT_MASK/EMIT_DATA, in_ready SHALL be 0.
REQ-023 Header beat SHALL drive out_is_mask=1, out_data=mask, out_num_dense=0 and out_last=(nnz==0).
REQ-024 Header accepted with nnz==0 SHALL return to COLLECT; otherwise the FSM SHALL go to EMIT_DATA with read pointer rd=0.
REQ-025 Payload beat SHALL drive lane i = packed[rd+i] for rd+i<nnz, and 0 otherwise.
REQ-026 Payload beat SHALL drive out_num_dense = min(OUT_LANES, nnz-rd).
REQ-027 Payload beat SHALL drive out_last=1 when rd+OUT_LANES >= nnz; accepting that beat SHALL return to COLLECT and clear pos, nnz, mask and rd.
REQ-028 A beat SHALL advance only when out_valid && out_ready.
REQ-029 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-030 Throughput: one beat per cycle under continuous out_ready; a block with n nonzeros SHALL occupy 1+ceil(n/OUT_LANES) output cycles.
REQ-031 Re-entry to COLLECT SHALL assert in_ready in the same cycle.
REQ-032 in_last on the first beat (pos 0) SHALL yield a one-position block.
REQ-033 in_last on beat BLOCK_SIZE-1 SHALL be equivalent to no in_last.

Reset
REQ-034 While resetn=0 at a clock edge: state=COLLECT; pos, nnz, rd, mask cleared; out_valid, out_is_mask, out_last=0; out_data, out_num_dense=0; in_ready=0.
REQ-035 in_ready SHALL be 1 in the first cycle after resetn returns to 1.
REQ-036 Reset mid-block SHALL discard the partial block; no beat of it SHALL appear after reset.

Structure
REQ-037 Shared package SHALL hold the state enum, VAL_WIDTH/BLOCK_SIZE/OUT_LANES defaults and the out_num_dense width, shared with the mask matcher.
REQ-038 Block SHALL be one module with no sub-modules; packed storage SHALL be a BLOCK_SIZE x VAL_WIDTH register array.

Verification
REQ-039 Feed 16 values 1..16 with out_ready=1 -> header 0xFFFF, then 8 payload beats {2,1},{4,3}..{16,15}, each num_dense=2, last on 8th.
REQ-040 Feed 16 zeros -> single beat mask 0x0000, out_is_mask=1, out_last=1; in_ready back to 1 the next cycle.
REQ-041 Feed values 5,0,0,7,0,9 with in_last on the 6th -> header 0x0029, then {7,5} num_dense=2, then {0,9} num_dense=1 with out_last=1.
REQ-042 Block as in REQ-039 with out_ready toggling 1,0,0,1 -> outputs stable on stalled cycles; sequence unchanged; in_ready=0 until the last payload beat is accepted.
REQ-043 resetn=0 after 7 input beats, then a fresh all-0x03 block -> first output is header 0xFFFF; no stale data appears.
REQ-044 Loopback: encoder output through the existing mask matcher against W mask 0xF00F -> matched pairs equal the dense golden model.
